// File: rtl/dispatch_wide.sv
// Multi-lane dispatch stage: buffers renamed packets in a circular queue and
// issues up to DISP_W of them per cycle, in program order, into the RS/ROB.

package dispatch_wide_pkg;
  localparam int FU_W = 2;

  localparam logic [FU_W-1:0] FU_ALU = 2'd0;
  localparam logic [FU_W-1:0] FU_BRU = 2'd1;
  localparam logic [FU_W-1:0] FU_LSU = 2'd2;

  // Renamed micro-op as delivered by rename.
  typedef struct packed {
    logic [7:0]      opcode;
    logic [FU_W-1:0] fu_type;
    logic [5:0]      pdst;
    logic [5:0]      psrc1;
    logic [5:0]      psrc2;
  } rename_pkt_t;

  // Reservation-station entry: the packet plus an occupancy bit.
  typedef struct packed {
    logic            valid;
    logic [7:0]      opcode;
    logic [FU_W-1:0] fu_type;
    logic [5:0]      pdst;
    logic [5:0]      psrc1;
    logic [5:0]      psrc2;
  } rs_entry_t;

  function automatic rs_entry_t to_rs_entry(input rename_pkt_t p);
    rs_entry_t e;
    e.valid   = 1'b1;
    e.opcode  = p.opcode;
    e.fu_type = p.fu_type;
    e.pdst    = p.pdst;
    e.psrc1   = p.psrc1;
    e.psrc2   = p.psrc2;
    return e;
  endfunction
endpackage

module dispatch_wide
  import dispatch_wide_pkg::*;
#(
  parameter int DISP_W = 2,
  parameter int DEPTH  = 8,
  parameter int NUM_RS = 3,
  parameter int FREE_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush_i,
  input  logic        [DISP_W-1:0]              valid_in,
  output logic                                  ready_out,
  input  rename_pkt_t [DISP_W-1:0]              pkt_in,
  input  logic        [NUM_RS-1:0][FREE_W-1:0]  rs_free_i,
  output logic        [NUM_RS-1:0][DISP_W-1:0]  rs_ins_valid_o,
  output rs_entry_t   [NUM_RS-1:0][DISP_W-1:0]  rs_ins_entry_o,
  input  logic        [FREE_W-1:0]              rob_free_i,
  output logic        [DISP_W-1:0]              rob_alloc_valid_o,
  output rename_pkt_t [DISP_W-1:0]              rob_alloc_pkt_o,
  output logic        [CNT_W-1:0]               stall_rob_cnt_o,
  output logic        [CNT_W-1:0]               stall_rs_cnt_o,
  output logic                                  illegal_fu_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  // Queue state
  rename_pkt_t      mem_q [DEPTH];
  rename_pkt_t      mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] count_q, count_d;

  // Status state
  logic [CNT_W-1:0] stall_rob_cnt_q, stall_rob_cnt_d;
  logic [CNT_W-1:0] stall_rs_cnt_q, stall_rs_cnt_d;
  logic             illegal_fu_q, illegal_fu_d;

  // Dispatch-selection results shared with the next-state logic
  logic [OCC_W-1:0]              deq_cnt;
  logic                          head_legal;
  logic [NUM_RS-1:0][FREE_W-1:0] rs_used;

  // In-order candidate selection and RS/ROB output steering.
  always_comb begin
    logic             chain;
    logic [PTR_W-1:0] idx;
    rename_pkt_t      cand;
    logic             legal;
    logic             rs_ok;
    logic [FREE_W-1:0] slot;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, so no path leaves a value held (no latch).
    deq_cnt           = '0;
    head_legal        = 1'b1;
    rs_used           = '0;
    rs_ins_valid_o    = '0;
    rs_ins_entry_o    = '0;
    rob_alloc_valid_o = '0;
    rob_alloc_pkt_o   = '0;
    chain             = !flush_i && !rst;

    for (int k = 0; k < DISP_W; k++) begin
      idx   = head_q + PTR_W'(k);
      cand  = mem_q[idx];
      legal = 1'b0;
      rs_ok = 1'b0;
      slot  = '0;
      for (int r = 0; r < NUM_RS; r++) begin
        if (cand.fu_type == FU_W'(r)) begin
          legal = 1'b1;
          slot  = rs_used[r];
          rs_ok = rs_free_i[r] > rs_used[r];
        end
      end
      if (k == 0) head_legal = legal;

      // A candidate fires only if every older one did: strict program order.
      if (chain && (count_q > OCC_W'(k)) && (rob_free_i > FREE_W'(k)) && legal && rs_ok) begin
        deq_cnt              = deq_cnt + 1'b1;
        rob_alloc_valid_o[k] = 1'b1;
        rob_alloc_pkt_o[k]   = cand;
        for (int r = 0; r < NUM_RS; r++) begin
          if (cand.fu_type == FU_W'(r)) begin
            for (int j = 0; j < DISP_W; j++) begin
              if (slot == FREE_W'(j)) begin
                rs_ins_valid_o[r][j] = 1'b1;
                rs_ins_entry_o[r][j] = to_rs_entry(cand);
              end
            end
            rs_used[r] = rs_used[r] + 1'b1;
          end
        end
      end else begin
        chain = 1'b0;
      end
    end
  end

  // Enqueue, pointer/occupancy update, stall counters and sticky illegal flag.
  always_comb begin
    logic [OCC_W-1:0] enq_cnt;

    mem_d   = mem_q;
    enq_cnt = '0;

    // Depends on registered occupancy only, never on this cycle's dispatch.
    ready_out = ((OCC_W'(DEPTH) - count_q) >= OCC_W'(DISP_W)) && !flush_i;

    for (int k = 0; k < DISP_W; k++) begin
      if (ready_out && valid_in[k]) begin
        mem_d[tail_q + PTR_W'(enq_cnt)] = pkt_in[k];
        enq_cnt = enq_cnt + 1'b1;
      end
    end

    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(deq_cnt);
      tail_d  = tail_q + PTR_W'(enq_cnt);
      count_d = count_q + enq_cnt - deq_cnt;
    end

    stall_rob_cnt_d = stall_rob_cnt_q;
    stall_rs_cnt_d  = stall_rs_cnt_q;
    if ((count_q != '0) && !flush_i && !rob_alloc_valid_o[0]) begin
      if (rob_free_i == '0) begin
        if (stall_rob_cnt_q != '1) stall_rob_cnt_d = stall_rob_cnt_q + 1'b1;
      end else begin
        if (stall_rs_cnt_q != '1) stall_rs_cnt_d = stall_rs_cnt_q + 1'b1;
      end
    end

    // An illegal head never fires, so the queue stays wedged until flush.
    illegal_fu_d = illegal_fu_q | ((count_q != '0) && !head_legal);
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only; the blocking
    // ones above are confined to combinational logic.
    if (rst) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      stall_rob_cnt_q <= '0;
      stall_rs_cnt_q  <= '0;
      illegal_fu_q    <= 1'b0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      stall_rob_cnt_q <= stall_rob_cnt_d;
      stall_rs_cnt_q  <= stall_rs_cnt_d;
      illegal_fu_q    <= illegal_fu_d;
    end
  end

  // Packet storage.
  // NOTE: the payload array has no reset; an entry is only read once count
  // covers it, so clearing it would cost flops for nothing.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign stall_rob_cnt_o = stall_rob_cnt_q;
  assign stall_rs_cnt_o  = stall_rs_cnt_q;
  assign illegal_fu_o    = illegal_fu_q;

  // Rename must present valid lanes packed from lane 0.
  a_valid_contig : assert property (@(posedge clk) disable iff (rst)
    ((valid_in & (valid_in + 1'b1)) == '0));

endmodule

// File: tb/tb_dispatch_wide.sv
// Directed self-checking bench for dispatch_wide.
`timescale 1ns/1ps

module tb_dispatch_wide;
  import dispatch_wide_pkg::*;

  localparam int DISP_W = 2;
  localparam int NUM_RS = 3;
  localparam int FREE_W = 4;
  localparam int CNT_W  = 32;

  logic                                 clk;
  logic                                 rst;
  logic                                 flush_i;
  logic        [DISP_W-1:0]             valid_in;
  logic                                 ready_out;
  rename_pkt_t [DISP_W-1:0]             pkt_in;
  logic        [NUM_RS-1:0][FREE_W-1:0] rs_free_i;
  logic        [NUM_RS-1:0][DISP_W-1:0] rs_ins_valid_o;
  rs_entry_t   [NUM_RS-1:0][DISP_W-1:0] rs_ins_entry_o;
  logic        [FREE_W-1:0]             rob_free_i;
  logic        [DISP_W-1:0]             rob_alloc_valid_o;
  rename_pkt_t [DISP_W-1:0]             rob_alloc_pkt_o;
  logic        [CNT_W-1:0]              stall_rob_cnt_o;
  logic        [CNT_W-1:0]              stall_rs_cnt_o;
  logic                                 illegal_fu_o;

  int checks   = 0;
  int failures = 0;

  dispatch_wide #(
    .DISP_W(DISP_W), .DEPTH(8), .NUM_RS(NUM_RS), .FREE_W(FREE_W), .CNT_W(CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush_i),
    .valid_in         (valid_in),
    .ready_out        (ready_out),
    .pkt_in           (pkt_in),
    .rs_free_i        (rs_free_i),
    .rs_ins_valid_o   (rs_ins_valid_o),
    .rs_ins_entry_o   (rs_ins_entry_o),
    .rob_free_i       (rob_free_i),
    .rob_alloc_valid_o(rob_alloc_valid_o),
    .rob_alloc_pkt_o  (rob_alloc_pkt_o),
    .stall_rob_cnt_o  (stall_rob_cnt_o),
    .stall_rs_cnt_o   (stall_rs_cnt_o),
    .illegal_fu_o     (illegal_fu_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic rename_pkt_t mkp(input logic [7:0] op, input logic [1:0] fu);
    rename_pkt_t p;
    p.opcode  = op;
    p.fu_type = fu;
    p.pdst    = op[5:0];
    p.psrc1   = op[5:0] ^ 6'h15;
    p.psrc2   = ~op[5:0];
    return p;
  endfunction

  function automatic rs_entry_t exp_ent(input rename_pkt_t p);
    rs_entry_t e;
    e = {1'b1, p.opcode, p.fu_type, p.pdst, p.psrc1, p.psrc2};
    return e;
  endfunction

  // Sequence-numbered packet: even numbers go to the ALU, odd to the LSU.
  function automatic rename_pkt_t seqp(input int s);
    logic [7:0] op;
    op = 8'(s);
    return mkp(op, op[0] ? FU_LSU : FU_ALU);
  endfunction

  task automatic drive(input logic [1:0] v, input rename_pkt_t p0, input rename_pkt_t p1);
    valid_in  = v;
    pkt_in[0] = p0;
    pkt_in[1] = p1;
  endtask

  task automatic set_rs(input logic [3:0] f0, input logic [3:0] f1, input logic [3:0] f2);
    rs_free_i[0] = f0;
    rs_free_i[1] = f1;
    rs_free_i[2] = f2;
  endtask

  rename_pkt_t p0, p1, p2, p3, p4, p5, p6, pa, pb;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    flush_i  = 1'b0;
    valid_in = '0;
    pkt_in   = '0;
    set_rs(4'd4, 4'd4, 4'd4);
    rob_free_i = 4'd4;

    // ---- Reset state
    #3;
    check("rst_ready", 64'(ready_out), 64'(1'b1));
    check("rst_rob_v", 64'(rob_alloc_valid_o), 64'(0));
    check("rst_rs_v", 64'(rs_ins_valid_o), 64'(0));
    check("rst_pkt", 64'(rob_alloc_pkt_o), 64'(0));
    check("rst_stall_rob", 64'(stall_rob_cnt_o), 64'(0));
    check("rst_stall_rs", 64'(stall_rs_cnt_o), 64'(0));
    check("rst_illegal", 64'(illegal_fu_o), 64'(0));
    @(posedge clk);
    #2 rst = 1'b0;

    // ---- Dual-lane dispatch: ALU + LSU, no bypass in the enqueue cycle
    p0 = mkp(8'h11, FU_ALU);
    p1 = mkp(8'h22, FU_LSU);
    drive(2'b11, p0, p1);
    #1;
    check("dual_enq_ready", 64'(ready_out), 64'(1'b1));
    check("dual_no_bypass", 64'(rob_alloc_valid_o), 64'(0));
    tick();
    drive(2'b00, '0, '0);
    #1;
    check("dual_rob_v", 64'(rob_alloc_valid_o), 64'(2'b11));
    check("dual_rob_p0", 64'(rob_alloc_pkt_o[0]), 64'(p0));
    check("dual_rob_p1", 64'(rob_alloc_pkt_o[1]), 64'(p1));
    check("dual_rs_v", 64'(rs_ins_valid_o), 64'({2'b01, 2'b00, 2'b01}));
    check("dual_rs0_e", 64'(rs_ins_entry_o[0][0]), 64'(exp_ent(p0)));
    check("dual_rs2_e", 64'(rs_ins_entry_o[2][0]), 64'(exp_ent(p1)));
    check("dual_rs2_s1", 64'(rs_ins_entry_o[2][1]), 64'(0));
    tick();
    #1;
    check("dual_empty", 64'(rob_alloc_valid_o), 64'(0));

    // ---- Same-RS conflict: two ALU packets, one ALU slot free
    p2 = mkp(8'h33, FU_ALU);
    p3 = mkp(8'h44, FU_ALU);
    drive(2'b11, p2, p3);
    tick();
    drive(2'b00, '0, '0);
    set_rs(4'd1, 4'd4, 4'd4);
    #1;
    check("conf_rob_v", 64'(rob_alloc_valid_o), 64'(2'b01));
    check("conf_rob_p0", 64'(rob_alloc_pkt_o[0]), 64'(p2));
    check("conf_rob_p1_zero", 64'(rob_alloc_pkt_o[1]), 64'(0));
    check("conf_rs_v", 64'(rs_ins_valid_o), 64'({2'b00, 2'b00, 2'b01}));
    tick();
    #1;
    check("conf_stall_rs", 64'(stall_rs_cnt_o), 64'(0));
    check("conf2_rob_v", 64'(rob_alloc_valid_o), 64'(2'b01));
    check("conf2_rob_p0", 64'(rob_alloc_pkt_o[0]), 64'(p3));
    check("conf2_rs_e", 64'(rs_ins_entry_o[0][0]), 64'(exp_ent(p3)));
    tick();
    set_rs(4'd4, 4'd4, 4'd4);
    #1;
    check("conf_empty", 64'(rob_alloc_valid_o), 64'(0));

    // ---- ROB stall for three cycles, then one ROB slot
    p4 = mkp(8'h55, FU_ALU);
    p5 = mkp(8'h66, FU_BRU);
    drive(2'b11, p4, p5);
    tick();
    drive(2'b00, '0, '0);
    rob_free_i = 4'd0;
    #1;
    check("robst_none", 64'(rob_alloc_valid_o), 64'(0));
    tick();
    tick();
    tick();
    rob_free_i = 4'd1;
    #1;
    check("robst_cnt", 64'(stall_rob_cnt_o), 64'(3));
    check("robst_rs_cnt", 64'(stall_rs_cnt_o), 64'(0));
    check("robst_one", 64'(rob_alloc_valid_o), 64'(2'b01));
    check("robst_p0", 64'(rob_alloc_pkt_o[0]), 64'(p4));
    tick();
    #1;
    check("robst_cnt_hold", 64'(stall_rob_cnt_o), 64'(3));
    check("robst2_one", 64'(rob_alloc_valid_o), 64'(2'b01));
    check("robst2_rs_v", 64'(rs_ins_valid_o), 64'({2'b00, 2'b01, 2'b00}));
    check("robst2_e", 64'(rs_ins_entry_o[1][0]), 64'(exp_ent(p5)));
    tick();
    rob_free_i = 4'd4;

    // ---- Fill to full with every RS blocked
    set_rs(4'd0, 4'd0, 4'd0);
    for (int c = 0; c < 4; c++) begin
      drive(2'b11, seqp(2 * c), seqp(2 * c + 1));
      #1;
      check($sformatf("fill_ready%0d", c), 64'(ready_out), 64'(1'b1));
      tick();
    end
    drive(2'b00, '0, '0);
    #1;
    check("full_ready", 64'(ready_out), 64'(1'b0));
    check("full_blocked", 64'(rob_alloc_valid_o), 64'(0));
    check("full_stall_rs", 64'(stall_rs_cnt_o), 64'(3));
    set_rs(4'd4, 4'd4, 4'd4);
    #1;
    check("full_rel_v", 64'(rob_alloc_valid_o), 64'(2'b11));
    check("full_rel_p0", 64'(rob_alloc_pkt_o[0]), 64'(seqp(0)));
    check("full_rel_p1", 64'(rob_alloc_pkt_o[1]), 64'(seqp(1)));
    tick();

    // ---- Steady 2-in / 2-out across many pointer wraps
    for (int i = 0; i < 20; i++) begin
      drive(2'b11, seqp(8 + 2 * i), seqp(9 + 2 * i));
      #1;
      check($sformatf("wrap_ready%0d", i), 64'(ready_out), 64'(1'b1));
      check($sformatf("wrap_v%0d", i), 64'(rob_alloc_valid_o), 64'(2'b11));
      check($sformatf("wrap_p0_%0d", i), 64'(rob_alloc_pkt_o[0]), 64'(seqp(2 + 2 * i)));
      check($sformatf("wrap_p1_%0d", i), 64'(rob_alloc_pkt_o[1]), 64'(seqp(3 + 2 * i)));
      tick();
    end
    drive(2'b00, '0, '0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("drain_p0_%0d", i), 64'(rob_alloc_pkt_o[0]), 64'(seqp(42 + 2 * i)));
      check($sformatf("drain_p1_%0d", i), 64'(rob_alloc_pkt_o[1]), 64'(seqp(43 + 2 * i)));
      tick();
    end
    #1;
    check("wrap_empty", 64'(rob_alloc_valid_o), 64'(0));
    check("wrap_stall_rs", 64'(stall_rs_cnt_o), 64'(3));

    // ---- Illegal fu_type at head, then flush
    p6 = mkp(8'h77, 2'd3);
    drive(2'b11, p6, mkp(8'h78, FU_ALU));
    tick();
    drive(2'b00, '0, '0);
    #1;
    check("ill_blocked", 64'(rob_alloc_valid_o), 64'(0));
    tick();
    #1;
    check("ill_sticky", 64'(illegal_fu_o), 64'(1'b1));
    check("ill_still_blocked", 64'(rob_alloc_valid_o), 64'(0));
    check("ill_stall_rs", 64'(stall_rs_cnt_o), 64'(4));
    flush_i = 1'b1;
    drive(2'b11, mkp(8'h81, FU_ALU), mkp(8'h82, FU_BRU));
    #1;
    check("flush_ready", 64'(ready_out), 64'(1'b0));
    check("flush_no_rob", 64'(rob_alloc_valid_o), 64'(0));
    check("flush_no_rs", 64'(rs_ins_valid_o), 64'(0));
    tick();
    flush_i = 1'b0;
    drive(2'b00, '0, '0);
    #1;
    check("post_flush_empty", 64'(rob_alloc_valid_o), 64'(0));
    check("post_flush_ready", 64'(ready_out), 64'(1'b1));
    check("post_flush_ill", 64'(illegal_fu_o), 64'(1'b1));
    check("post_flush_stall", 64'(stall_rs_cnt_o), 64'(4));
    pa = mkp(8'h91, FU_BRU);
    drive(2'b01, pa, '0);
    tick();
    drive(2'b00, '0, '0);
    #1;
    check("post_flush_v", 64'(rob_alloc_valid_o), 64'(2'b01));
    check("post_flush_p", 64'(rob_alloc_pkt_o[0]), 64'(pa));
    tick();

    // ---- Asynchronous reset while packets are firing
    pb = mkp(8'hA1, FU_ALU);
    drive(2'b11, pb, mkp(8'hA2, FU_LSU));
    tick();
    drive(2'b00, '0, '0);
    #1;
    check("prerst_v", 64'(rob_alloc_valid_o), 64'(2'b11));
    rst = 1'b1;
    #1;
    check("midrst_rob_v", 64'(rob_alloc_valid_o), 64'(0));
    check("midrst_rs_v", 64'(rs_ins_valid_o), 64'(0));
    check("midrst_ill", 64'(illegal_fu_o), 64'(0));
    check("midrst_stall_rs", 64'(stall_rs_cnt_o), 64'(0));
    check("midrst_stall_rob", 64'(stall_rob_cnt_o), 64'(0));
    check("midrst_ready", 64'(ready_out), 64'(1'b1));
    #1 rst = 1'b0;
    tick();
    #1;
    check("postrst_empty", 64'(rob_alloc_valid_o), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
